// File: rtl/serial_frame_sched_pkg.sv
// Shared definitions for the sample-frame transmit scheduler and its receive-side parser.
// Frame layout: HEADER, type, data[15:8], data[7:0], checksum (sum of bytes 1..3 mod 256).
package serial_frame_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } sched_state_e;

    localparam logic [7:0] TYPE_HR   = 8'h01;
    localparam logic [7:0] TYPE_SPO2 = 8'h02;
    localparam int         FRAME_LEN = 5;
    localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);

    function automatic logic [7:0] frame_byte(
        input logic [2:0]  idx,
        input logic [7:0]  hdr,
        input logic [7:0]  ftype,
        input logic [15:0] data
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = hdr;
            3'd1:    b = ftype;
            3'd2:    b = data[15:8];
            3'd3:    b = data[7:0];
            default: b = ftype + data[15:8] + data[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/serial_frame_sched.sv
// Round-robin scheduler that packs HR / SpO2 samples into 5-byte frames for a byte transmitter.
// state | meaning: IDLE wait for sample | LOAD latch header | SEND start pulse | WAIT await tx_done
module serial_frame_sched
    import serial_frame_sched_pkg::*;
#(
    parameter logic [7:0]  HEADER      = 8'hAA,
    parameter logic [15:0] TIMEOUT_CYC = 16'd60000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        hr_valid,
    input  logic [15:0] hr_data,
    output logic        hr_ready,
    input  logic        spo2_valid,
    input  logic [15:0] spo2_data,
    output logic        spo2_ready,
    output logic        tx_send_en,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [15:0] WAIT_LAST = TIMEOUT_CYC - 16'd1;

    sched_state_e state, state_nxt;
    logic [2:0]   byte_idx;
    logic [15:0]  wait_cnt;
    logic [7:0]   frame_type;
    logic [15:0]  frame_data;
    logic         last_spo2;
    logic         run;
    logic         accept_hr, accept_spo2;
    logic         wait_expire;

    // run keeps the ready strobes quiet while Rst is high and for the release cycle
    always_comb begin
        accept_hr   = 1'b0;
        accept_spo2 = 1'b0;
        if (state == ST_IDLE && run) begin
            accept_hr   = hr_valid && (!spo2_valid || last_spo2);
            accept_spo2 = spo2_valid && !accept_hr;
        end
    end

    assign wait_expire = (state == ST_WAIT) && !tx_done && (wait_cnt == WAIT_LAST);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept_hr || accept_spo2) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_SEND;
            ST_SEND: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) begin
                    state_nxt = (byte_idx == LAST_IDX) ? ST_IDLE : ST_SEND;
                end else if (wait_expire) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        hr_ready    = accept_hr;
        spo2_ready  = accept_spo2;
        tx_send_en  = (state == ST_SEND);
        busy        = (state != ST_IDLE);
        timeout_err = wait_expire;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            run        <= 1'b0;
            byte_idx   <= 3'd0;
            wait_cnt   <= 16'd0;
            frame_type <= 8'h00;
            frame_data <= 16'h0000;
            last_spo2  <= 1'b1;
            tx_data    <= 8'h00;
        end else begin
            run      <= 1'b1;
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 16'd1 : 16'd0;
            case (state)
                ST_IDLE: begin
                    byte_idx <= 3'd0;
                    if (accept_hr) begin
                        frame_type <= TYPE_HR;
                        frame_data <= hr_data;
                        last_spo2  <= 1'b0;
                    end else if (accept_spo2) begin
                        frame_type <= TYPE_SPO2;
                        frame_data <= spo2_data;
                        last_spo2  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    byte_idx <= 3'd0;
                    tx_data  <= HEADER;
                end
                ST_WAIT: begin
                    if (tx_done && byte_idx != LAST_IDX) begin
                        byte_idx <= byte_idx + 3'd1;
                        tx_data  <= frame_byte(byte_idx + 3'd1, HEADER, frame_type, frame_data);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_sched.sv
// Directed bench for serial_frame_sched: frames, round-robin, checksum wrap, timeout and reset.
module tb_serial_frame_sched;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        hr_valid, spo2_valid, tx_done;
    logic [15:0] hr_data, spo2_data;
    logic        hr_ready, spo2_ready, tx_send_en, busy, timeout_err;
    logic [7:0]  tx_data;

    int vectors     = 0;
    int miscompares = 0;
    int send_cnt    = 0;
    int hr_rdy_cnt  = 0;
    int base_cnt    = 0;
    int k           = 0;
    logic [7:0] got [5];

    serial_frame_sched #(.HEADER(8'hAA), .TIMEOUT_CYC(16'd100)) dut (
        .Clk(Clk), .Rst(Rst),
        .hr_valid(hr_valid), .hr_data(hr_data), .hr_ready(hr_ready),
        .spo2_valid(spo2_valid), .spo2_data(spo2_data), .spo2_ready(spo2_ready),
        .tx_send_en(tx_send_en), .tx_data(tx_data), .tx_done(tx_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (tx_send_en) send_cnt++;
        if (hr_ready) hr_rdy_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    // start pulse must already be present when called; any lateness shows as nonzero
    task automatic wait_send(input string tag);
        int n = 0;
        while (tx_send_en !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 16'(n), 16'd0);
    endtask

    task automatic run_frame(input int gap);
        for (int b = 0; b < 5; b++) begin
            wait_send($sformatf("send_lat_b%0d", b));
            got[b] = tx_data;
            repeat (gap) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
    endtask

    task automatic chk_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
        logic [7:0] e [5];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
        for (int i = 0; i < 5; i++) chk($sformatf("%s_b%0d", tag, i), 16'(got[i]), 16'(e[i]));
    endtask

    initial begin
        Rst = 1'b1; hr_valid = 1'b0; spo2_valid = 1'b0; tx_done = 1'b0;
        hr_data = 16'h0000; spo2_data = 16'h0000;
        repeat (3) tick();
        hr_valid = 1'b1;
        #1;
        chk("rst_hr_ready", 16'(hr_ready), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_tx_data", 16'(tx_data), 16'h00);
        chk("rst_send", 16'(tx_send_en), 16'd0);
        chk("rst_timeout", 16'(timeout_err), 16'd0);
        hr_valid = 1'b0;
        Rst = 1'b0;
        tick();

        // single HR frame
        hr_valid = 1'b1; hr_data = 16'h0048;
        #1;
        chk("t1_hr_ready", 16'(hr_ready), 16'd1);
        chk("t1_spo2_ready", 16'(spo2_ready), 16'd0);
        tick();
        hr_valid = 1'b0;
        #1;
        chk("t1_load_busy", 16'(busy), 16'd1);
        chk("t1_load_send", 16'(tx_send_en), 16'd0);
        tick();
        run_frame(10);
        chk_frame("t1", 8'hAA, 8'h01, 8'h00, 8'h48, 8'h49);
        chk("t1_end_busy", 16'(busy), 16'd0);
        chk("t1_hr_pulses", 16'(hr_rdy_cnt), 16'd1);

        // simultaneous requests: HR first after reset, then alternate
        Rst = 1'b1; tick(); Rst = 1'b0; tick();
        hr_valid = 1'b1; spo2_valid = 1'b1; hr_data = 16'h0010; spo2_data = 16'h0062;
        #1;
        chk("t2_hr_first", 16'(hr_ready), 16'd1);
        chk("t2_spo2_wait", 16'(spo2_ready), 16'd0);
        tick();
        #1;
        chk("t2_no_ready_busy", 16'(spo2_ready), 16'd0);
        tick();
        run_frame(10);
        chk_frame("t2_hr", 8'hAA, 8'h01, 8'h00, 8'h10, 8'h11);
        hr_data = 16'hFFFF;
        #1;
        chk("t2_rr_spo2", 16'(spo2_ready), 16'd1);
        chk("t2_rr_no_hr", 16'(hr_ready), 16'd0);
        tick();
        spo2_valid = 1'b0;
        tick();
        run_frame(4);
        chk_frame("t2_spo2", 8'hAA, 8'h02, 8'h00, 8'h62, 8'h64);
        #1;
        chk("t3_rr_hr", 16'(hr_ready), 16'd1);
        tick();
        hr_valid = 1'b0;
        tick();
        run_frame(4);
        chk_frame("t3_wrap", 8'hAA, 8'h01, 8'hFF, 8'hFF, 8'hFF);

        // timeout with no tx_done
        hr_valid = 1'b1; hr_data = 16'h0501;
        #1;
        chk("t4_hr_ready", 16'(hr_ready), 16'd1);
        tick();
        hr_valid = 1'b0;
        tick();
        chk("t4_send", 16'(tx_send_en), 16'd1);
        k = 0;
        while (timeout_err !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        chk("t4_timeout_lat", 16'(k), 16'd100);
        chk("t4_busy_at_abort", 16'(busy), 16'd1);
        tick();
        chk("t4_busy_after", 16'(busy), 16'd0);
        chk("t4_pulse_width", 16'(timeout_err), 16'd0);
        hr_valid = 1'b1;
        #1;
        chk("t4_idle_ready", 16'(hr_ready), 16'd1);

        // tx_done coincident with threshold counts as success
        tick();
        hr_valid = 1'b0;
        tick();
        chk("t5_send", 16'(tx_send_en), 16'd1);
        repeat (100) tick();
        tx_done = 1'b1;
        #1;
        chk("t5_no_abort", 16'(timeout_err), 16'd0);
        tick();
        tx_done = 1'b0;
        #1;
        chk("t5_next_send", 16'(tx_send_en), 16'd1);
        chk("t5_byte1", 16'(tx_data), 16'h01);
        repeat (10) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("t5_byte2", 16'(tx_data), 16'h05);

        // reset during WAIT of byte 2
        repeat (3) tick();
        Rst = 1'b1;
        #1;
        chk("t6_busy", 16'(busy), 16'd0);
        chk("t6_tx_data", 16'(tx_data), 16'h00);
        chk("t6_send", 16'(tx_send_en), 16'd0);
        chk("t6_timeout", 16'(timeout_err), 16'd0);
        base_cnt = send_cnt;
        tick(); tick();
        Rst = 1'b0;
        repeat (20) tick();
        chk("t6_no_resume", 16'(send_cnt - base_cnt), 16'd0);

        // spurious tx_done in IDLE, then a fresh frame from the header
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        #1;
        chk("t7_busy", 16'(busy), 16'd0);
        chk("t7_send", 16'(tx_send_en), 16'd0);
        hr_valid = 1'b1; hr_data = 16'h0102;
        #1;
        chk("t7_hr_ready", 16'(hr_ready), 16'd1);
        tick();
        hr_valid = 1'b0;
        tick();
        run_frame(3);
        chk_frame("t7", 8'hAA, 8'h01, 8'h01, 8'h02, 8'h04);
        chk("t7_end_busy", 16'(busy), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_frame_sched.md
SERIAL_FRAME_SCHED -- requirements
Module: serial_frame_sched

Interface
REQ-001 SHALL have parameter HEADER, default 8'hAA, frame start byte.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16'd60000, maximum cycles to wait for tx_done per byte.
REQ-003 SHALL have port Clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port Rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port hr_valid  input  1  heart-rate sample pending.
REQ-006 SHALL have port hr_data  input  16  heart-rate value.
REQ-007 SHALL have port hr_ready  output  1  one-cycle accept strobe for hr_data.
REQ-008 SHALL have port spo2_valid  input  1  SpO2 sample pending.
REQ-009 SHALL have port spo2_data  input  16  SpO2 value.
REQ-010 SHALL have port spo2_ready  output  1  one-cycle accept strobe for spo2_data.
REQ-011 SHALL have port tx_send_en  output  1  one-cycle start pulse to the byte transmitter.
REQ-012 SHALL have port tx_data  output  8  byte presented to the transmitter, held stable until tx_done.
REQ-013 SHALL have port tx_done  input  1  one-cycle byte-complete pulse from the transmitter.
REQ-014 SHALL have port busy  output  1  high from acceptance until frame end or abort.
REQ-015 SHALL have port timeout_err  output  1  one-cycle pulse on frame abort.

Function
REQ-016 SHALL emit each accepted sample as a 5-byte frame: HEADER, type (8'h01 HR, 8'h02 SpO2), data[15:8], data[7:0], checksum.
REQ-017 SHALL compute checksum as the sum of bytes 1..3 modulo 256, carries discarded.
REQ-018 SHALL implement states IDLE -> LOAD -> SEND -> WAIT -> (SEND for next byte | IDLE after byte 4).
REQ-019 SHALL, in IDLE with any valid high, assert exactly one ready for one cycle and capture that source's data that cycle.
REQ-020 SHALL arbitrate round-robin: with both valid, grant the source not served last; after reset, HR has priority.
REQ-021 SHALL never assert hr_ready or spo2_ready outside IDLE; valid held during a frame waits.
REQ-022 SHALL pulse tx_send_en for byte 0 exactly two cycles after the ready cycle (LOAD, then SEND).
REQ-023 SHALL pulse tx_send_en for each later byte one cycle after the tx_done ending the previous byte.
REQ-024 SHALL ignore tx_done outside WAIT.
REQ-025 SHALL return to IDLE the cycle after tx_done of byte 4; busy SHALL drop that same cycle.
REQ-026 SHALL count cycles in WAIT; on reaching TIMEOUT_CYC without tx_done, abort the frame, pulse timeout_err, and return to IDLE; the sample is dropped.
REQ-027 SHALL treat tx_done arriving in the same cycle the count reaches TIMEOUT_CYC as success (no abort).

Reset
REQ-028 SHALL, while Rst high, force state IDLE, hr_ready=0, spo2_ready=0, tx_send_en=0, tx_data=8'h00, busy=0, timeout_err=0, byte index=0, timeout count=0, last-served=SpO2.
REQ-029 SHALL discard any in-progress frame on reset; no resumption after release.

Structure
REQ-030 SHALL place frame type codes, frame length (5), and state encoding in a shared package used by this block and the receive-side parser.
REQ-031 SHALL contain no sub-module; the existing byte transmitter is instantiated alongside in the parent and wired to tx_send_en/tx_data/tx_done.

Verification
REQ-032 SHALL cover: hr_valid, hr_data=16'h0048, tx_done 10 cycles after each tx_send_en -> bytes AA 01 00 48 49, one hr_ready pulse.
REQ-033 SHALL cover: hr_valid and spo2_valid both high after reset, spo2_data=16'h0062 -> HR frame first, then AA 02 00 62 64; the next simultaneous request grants SpO2 first.
REQ-034 SHALL cover: hr_data=16'hFFFF -> bytes AA 01 FF FF FF (checksum wrap).
REQ-035 SHALL cover: TIMEOUT_CYC=100, tx_done never asserted -> timeout_err pulse 100 cycles after first tx_send_en, busy low, IDLE next cycle.
REQ-036 SHALL cover: Rst asserted during WAIT of byte 2 -> all outputs at reset values immediately, no further tx_send_en; a new request after release starts at HEADER.
REQ-037 SHALL cover: spurious tx_done in IDLE and a tx_done coincident with the timeout threshold -> no state change and no abort, respectively.
